// File: rtl/udp_tx_scheduler_pkg.sv
// Shared definitions for the UDP transmit scheduler: FSM state encoding,
// default payload limit and the width of one ch_len/ch_port lane.
package udp_tx_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_START,
    ST_SEND,
    ST_GAP
  } sched_state_t;

  localparam int unsigned DEF_MAX_LEN = 1472;
  localparam int unsigned LANE_W      = 16;

endpackage

// File: rtl/udp_tx_scheduler_if.sv
// Channel request side and UDP sender side of the scheduler, bundled.
interface udp_tx_scheduler_if
  import udp_tx_scheduler_pkg::*;
#(
  parameter int unsigned N_CH = 4
);
  logic [N_CH-1:0]        ch_req;
  logic [LANE_W*N_CH-1:0] ch_len;
  logic [LANE_W*N_CH-1:0] ch_port;
  logic [N_CH-1:0]        ch_mask;
  logic                   end_tx;
  logic                   en;
  logic [LANE_W-1:0]      mem_length;
  logic [LANE_W-1:0]      port_dest;
  logic [2:0]             ch_sel;
  logic [N_CH-1:0]        ch_ack;
  logic [N_CH-1:0]        ch_drop;
  logic                   busy;
  logic                   timeout_err;

  modport master (
    output ch_req, ch_len, ch_port, ch_mask, end_tx,
    input  en, mem_length, port_dest, ch_sel, ch_ack, ch_drop, busy, timeout_err
  );

  modport slave (
    input  ch_req, ch_len, ch_port, ch_mask, end_tx,
    output en, mem_length, port_dest, ch_sel, ch_ack, ch_drop, busy, timeout_err
  );
endinterface

// File: rtl/udp_tx_scheduler_rr_arbiter.sv
// Round-robin priority search: first eligible channel after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N_CH = 4
) (
  input  logic [N_CH-1:0] req,
  input  logic [N_CH-1:0] mask,
  input  logic [2:0]      ptr,
  output logic [N_CH-1:0] grant,
  output logic [2:0]      idx,
  output logic            valid
);

  logic [N_CH-1:0] elig;
  assign elig = req & mask;

  // Walk distances 1..N_CH from the pointer; the first eligible hit wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    for (int unsigned k = 1; k <= N_CH; k++) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (!valid && elig[i] && (i == (32'(ptr) + k) % N_CH)) begin
          valid    = 1'b1;
          grant[i] = 1'b1;
          idx      = 3'(i);
        end
      end
    end
  end

endmodule

// File: rtl/udp_tx_scheduler.sv
// Frame scheduler: grants one payload channel at a time to the UDP sender,
// rejects illegal lengths, aborts stalled frames and spaces frames by GAP.
module udp_tx_scheduler
  import udp_tx_scheduler_pkg::*;
#(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned TIMEOUT = 4095,
  parameter int unsigned GAP     = 12,
  parameter int unsigned MAX_LEN = DEF_MAX_LEN
) (
  input  logic                clk,
  input  logic                rst,
  udp_tx_scheduler_if.slave   bus
);

  sched_state_t      state;
  logic [2:0]        rr_ptr;
  logic [11:0]       tmo_cnt;
  logic [15:0]       gap_cnt;
  logic [N_CH-1:0]   win_oh;

  logic              en_q;
  logic [LANE_W-1:0] len_q;
  logic [LANE_W-1:0] port_q;
  logic [2:0]        sel_q;
  logic [N_CH-1:0]   ack_q;
  logic [N_CH-1:0]   drop_q;
  logic              busy_q;
  logic              terr_q;

  logic [N_CH-1:0]   arb_grant;
  logic [2:0]        arb_idx;
  logic              arb_valid;
  logic [LANE_W-1:0] sel_len;
  logic [LANE_W-1:0] sel_port;
  logic              len_ok;
  logic              tmo_hit;

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req   (bus.ch_req),
    .mask  (bus.ch_mask),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  // Lane mux for the current arbitration winner.
  always_comb begin
    sel_len  = '0;
    sel_port = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (arb_grant[i]) begin
        sel_len  = bus.ch_len[i*LANE_W +: LANE_W];
        sel_port = bus.ch_port[i*LANE_W +: LANE_W];
      end
    end
  end

  assign len_ok  = (sel_len != '0) && (32'(sel_len) <= MAX_LEN);
  // Fires on the edge where the counter reaches TIMEOUT, so the abort pulse
  // is visible TIMEOUT+1 cycles after the en cycle.
  assign tmo_hit = (({1'b0, tmo_cnt} + 13'd1) == 13'(TIMEOUT));

  // Scheduler FSM with registered pulse and hold outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      rr_ptr  <= 3'(N_CH - 1);
      tmo_cnt <= '0;
      gap_cnt <= '0;
      win_oh  <= '0;
      en_q    <= 1'b0;
      len_q   <= '0;
      port_q  <= '0;
      sel_q   <= '0;
      ack_q   <= '0;
      drop_q  <= '0;
      busy_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      en_q   <= 1'b0;
      ack_q  <= '0;
      drop_q <= '0;
      terr_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|(bus.ch_req & bus.ch_mask)) begin
            state  <= ST_GRANT;
            busy_q <= 1'b1;
          end
        end
        ST_GRANT: begin
          if (arb_valid) begin
            len_q  <= sel_len;
            port_q <= sel_port;
            sel_q  <= arb_idx;
            win_oh <= arb_grant;
            rr_ptr <= arb_idx;
            if (len_ok) begin
              state <= ST_START;
              en_q  <= 1'b1;
            end else begin
              state   <= ST_GAP;
              drop_q  <= arb_grant;
              gap_cnt <= '0;
            end
          end else begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end
        end
        ST_START: begin
          state   <= ST_SEND;
          tmo_cnt <= '0;
        end
        ST_SEND: begin
          if (bus.end_tx) begin
            ack_q   <= win_oh;
            state   <= ST_GAP;
            gap_cnt <= '0;
          end else if (tmo_hit) begin
            drop_q  <= win_oh;
            terr_q  <= 1'b1;
            state   <= ST_GAP;
            gap_cnt <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 12'd1;
          end
        end
        ST_GAP: begin
          if (gap_cnt == 16'(GAP - 1)) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.en          = en_q;
  assign bus.mem_length  = len_q;
  assign bus.port_dest   = port_q;
  assign bus.ch_sel      = sel_q;
  assign bus.ch_ack      = ack_q;
  assign bus.ch_drop     = drop_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_udp_tx_scheduler.sv
// Self-checking bench for udp_tx_scheduler: directed scenarios plus random
// frames checked against a transaction-level round-robin model.
module tb_udp_tx_scheduler;

  localparam int N_CH    = 4;
  localparam int TIMEOUT = 4095;
  localparam int GAP     = 12;
  localparam int MAX_LEN = 1472;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  udp_tx_scheduler_if #(.N_CH(N_CH)) bus ();

  udp_tx_scheduler #(
    .N_CH(N_CH), .TIMEOUT(TIMEOUT), .GAP(GAP), .MAX_LEN(MAX_LEN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: last winner and the stimulus presented to the DUT.
  int          model_ptr;
  logic [3:0]  req_v, mask_v;
  int unsigned len_v  [N_CH];
  int unsigned port_v [N_CH];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic apply();
    bus.ch_req  = req_v;
    bus.ch_mask = mask_v;
    for (int i = 0; i < N_CH; i++) begin
      bus.ch_len[16*i +: 16]  = 16'(len_v[i]);
      bus.ch_port[16*i +: 16] = 16'(port_v[i]);
    end
  endtask

  function automatic int predict();
    for (int k = 1; k <= N_CH; k++) begin
      int c = (model_ptr + k) % N_CH;
      if (req_v[c] && mask_v[c]) return c;
    end
    return 0;
  endfunction

  function automatic int unsigned rand_len();
    int unsigned r = $urandom_range(0, 9);
    if (r == 0) return 0;
    if (r == 1) return MAX_LEN + 1 + $urandom_range(0, 500);
    if (r == 2) return MAX_LEN;
    return $urandom_range(1, MAX_LEN);
  endfunction

  task automatic randomize_inputs();
    do begin
      req_v  = 4'($urandom);
      mask_v = 4'($urandom);
    end while ((req_v & mask_v) == 4'h0);
    for (int i = 0; i < N_CH; i++) begin
      len_v[i]  = rand_len();
      port_v[i] = $urandom_range(0, 65535);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < GAP + 20) begin
      tick();
      n++;
    end
    check_eq("idle", 32'(bus.busy), 0);
  endtask

  // One frame from IDLE; d = SEND cycle carrying end_tx (0 = never).
  // Expects to be called at a negedge while the DUT is idle with no request.
  task automatic do_frame(input int d, input bit scramble);
    int w, waited, evt, en_extra, n, stray, exp_evt;
    bit ok, exp_ack;
    int unsigned exp_len, exp_port;
    w        = predict();
    ok       = (len_v[w] != 0) && (len_v[w] <= MAX_LEN);
    exp_len  = len_v[w] & 32'hFFFF;
    exp_port = port_v[w];
    apply();
    bus.end_tx = 1'b0;
    waited = 0;
    do begin
      tick();
      waited++;
    end while (!bus.en && bus.ch_drop == '0 && waited < 20);
    check_eq("grant_lat", waited, 2);
    check_eq("ch_sel", 32'(bus.ch_sel), w);
    check_eq("mem_length", 32'(bus.mem_length), exp_len);
    check_eq("port_dest", 32'(bus.port_dest), exp_port);
    model_ptr = w;
    if (ok) begin
      check_eq("en", 32'(bus.en), 1);
      check_eq("drop_at_en", 32'(bus.ch_drop), 0);
      if (scramble) begin
        randomize_inputs();
        apply();
      end
      exp_ack = (d >= 1) && (d <= TIMEOUT);
      exp_evt = exp_ack ? d + 1 : TIMEOUT + 1;
      evt = 0;
      en_extra = 0;
      for (int j = 0; j <= TIMEOUT + 8 && evt == 0; j++) begin
        if (d != 0 && j == d) bus.end_tx = 1'b1;
        else if (j == 0)      bus.end_tx = 1'($urandom);
        else                  bus.end_tx = 1'b0;
        tick();
        if (bus.en) en_extra++;
        if (bus.ch_ack != '0 || bus.ch_drop != '0) evt = j + 1;
      end
      bus.end_tx = 1'b0;
      check_eq("frame_len", evt, exp_evt);
      check_eq("ch_ack", 32'(bus.ch_ack), exp_ack ? (1 << w) : 0);
      check_eq("ch_drop", 32'(bus.ch_drop), exp_ack ? 0 : (1 << w));
      check_eq("timeout_err", 32'(bus.timeout_err), exp_ack ? 0 : 1);
      check_eq("en_once", en_extra, 0);
      check_eq("len_hold", 32'(bus.mem_length), exp_len);
      check_eq("port_hold", 32'(bus.port_dest), exp_port);
    end else begin
      check_eq("no_en", 32'(bus.en), 0);
      check_eq("ch_drop_rej", 32'(bus.ch_drop), 1 << w);
      check_eq("terr_rej", 32'(bus.timeout_err), 0);
    end
    bus.ch_req = '0;
    n = 0;
    stray = 0;
    while (bus.busy && n < GAP + 8) begin
      bus.end_tx = 1'($urandom);
      tick();
      n++;
      if (bus.en || bus.ch_ack != '0 || bus.ch_drop != '0 || bus.timeout_err) stray++;
    end
    bus.end_tx = 1'b0;
    check_eq("gap_len", n, GAP);
    check_eq("gap_quiet", stray, 0);
  endtask

  // Held requests on all channels: order and spacing of en pulses.
  task automatic rr_burst(input int d);
    int t, last, w, waited;
    req_v  = 4'hF;
    mask_v = 4'hF;
    for (int i = 0; i < N_CH; i++) begin
      len_v[i]  = 64;
      port_v[i] = 1000 + i;
    end
    apply();
    bus.end_tx = 1'b0;
    t = 0;
    last = 0;
    for (int f = 0; f < 5; f++) begin
      w = predict();
      waited = 0;
      while (!bus.en && waited < 60) begin
        tick();
        t++;
        waited++;
      end
      if (f == 0) check_eq("first_grant_lat", waited, 2);
      check_eq("burst_en", 32'(bus.en), 1);
      check_eq("burst_sel", 32'(bus.ch_sel), w);
      check_eq("burst_len", 32'(bus.mem_length), 64);
      model_ptr = w;
      if (f > 0) check_eq("burst_spacing", t - last, d + GAP + 3);
      last = t;
      for (int j = 0; j <= d; j++) begin
        bus.end_tx = (j == d);
        tick();
        t++;
      end
      bus.end_tx = 1'b0;
      check_eq("burst_ack", 32'(bus.ch_ack), 1 << w);
    end
    bus.ch_req = '0;
    wait_idle();
  endtask

  task automatic clear_lanes();
    for (int i = 0; i < N_CH; i++) begin
      len_v[i]  = 0;
      port_v[i] = 0;
    end
  endtask

  initial begin
    int n_pulse;
    rst         = 1'b1;
    bus.ch_req  = '0;
    bus.ch_mask = '0;
    bus.ch_len  = '0;
    bus.ch_port = '0;
    bus.end_tx  = 1'b0;
    model_ptr   = N_CH - 1;
    repeat (3) tick();
    check_eq("rst_busy", 32'(bus.busy), 0);
    check_eq("rst_en", 32'(bus.en), 0);
    check_eq("rst_len", 32'(bus.mem_length), 0);
    check_eq("rst_port", 32'(bus.port_dest), 0);
    check_eq("rst_sel", 32'(bus.ch_sel), 0);
    check_eq("rst_ack_drop", 32'({bus.ch_ack, bus.ch_drop}), 0);
    check_eq("rst_terr", 32'(bus.timeout_err), 0);
    rst = 1'b0;

    // Round-robin order from reset: 0,1,2,3,0.
    rr_burst(5);

    // Single channel, 40-byte frame, end_tx 70 cycles after en.
    clear_lanes();
    req_v = 4'b0001; mask_v = 4'hF; len_v[0] = 40; port_v[0] = 16'h1234;
    do_frame(70, 1'b0);

    // Zero length then oversize length: both rejected.
    clear_lanes();
    req_v = 4'b0100; mask_v = 4'hF; len_v[2] = 0; port_v[2] = 53;
    do_frame(5, 1'b0);
    len_v[2] = 1500;
    do_frame(5, 1'b0);

    // Masked requester is skipped.
    clear_lanes();
    req_v = 4'b1001; mask_v = 4'b0001; len_v[0] = 100; len_v[3] = 100;
    do_frame(3, 1'b0);

    // No end_tx: timeout abort.
    clear_lanes();
    req_v = 4'b0010; mask_v = 4'hF; len_v[1] = 512; port_v[1] = 9000;
    do_frame(0, 1'b0);

    // end_tx coincident with the timeout edge: ack wins.
    do_frame(TIMEOUT, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 25; i++) begin
      randomize_inputs();
      do_frame($urandom_range(1, 80), 1'($urandom));
    end

    // Reset 10 cycles into SEND.
    clear_lanes();
    req_v = 4'b0001; mask_v = 4'hF; len_v[0] = 200; port_v[0] = 77;
    apply();
    repeat (2) tick();
    check_eq("pre_rst_en", 32'(bus.en), 1);
    repeat (10) tick();
    #1 rst = 1'b1;
    #1;
    check_eq("arst_busy", 32'(bus.busy), 0);
    check_eq("arst_len", 32'(bus.mem_length), 0);
    check_eq("arst_port", 32'(bus.port_dest), 0);
    check_eq("arst_sel", 32'(bus.ch_sel), 0);
    check_eq("arst_pulses", 32'({bus.en, bus.ch_ack, bus.ch_drop, bus.timeout_err}), 0);
    n_pulse = 0;
    repeat (3) begin
      bus.end_tx = 1'b1;
      tick();
      if (bus.ch_ack != '0 || bus.ch_drop != '0) n_pulse++;
    end
    bus.end_tx = 1'b0;
    check_eq("arst_no_ack", n_pulse, 0);
    rst = 1'b0;
    model_ptr = N_CH - 1;
    len_v[0] = 40;
    do_frame(20, 1'b0);

    // Pointer restarts at N_CH-1 after reset: channel 0 beats channel 2.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_ptr = N_CH - 1;
    clear_lanes();
    req_v = 4'b0101; mask_v = 4'hF; len_v[0] = 10; len_v[2] = 10;
    do_frame(4, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
